// File: rtl/cp0_timer_intr_pkg.sv
// Shared definitions for the CP0 timer/interrupt block: register indices,
// field positions, writable-bit masks and the exception-code enum.
package cp0_timer_intr_pkg;

    localparam logic [4:0] CP0_BADVADDR = 5'd8;
    localparam logic [4:0] CP0_COUNT    = 5'd9;
    localparam logic [4:0] CP0_COMPARE  = 5'd11;
    localparam logic [4:0] CP0_STATUS   = 5'd12;
    localparam logic [4:0] CP0_CAUSE    = 5'd13;
    localparam logic [4:0] CP0_EPC      = 5'd14;
    localparam logic [4:0] CP0_PRID     = 5'd15;

    localparam int ST_IE     = 0;
    localparam int ST_EXL    = 1;
    localparam int ST_IM_LO  = 8;
    localparam int CA_EXC_LO = 2;
    localparam int CA_IP_LO  = 8;
    localparam int CA_TI     = 30;
    localparam int CA_BD     = 31;

    localparam logic [31:0] STATUS_WMASK = 32'h0000_ff03;
    localparam logic [31:0] CAUSE_WMASK  = 32'h0000_0300;

    typedef enum logic [4:0] {
        EXC_INT  = 5'd0,
        EXC_MOD  = 5'd1,
        EXC_TLBL = 5'd2,
        EXC_TLBS = 5'd3,
        EXC_ADEL = 5'd4,
        EXC_ADES = 5'd5,
        EXC_SYS  = 5'd8,
        EXC_BP   = 5'd9,
        EXC_RI   = 5'd10,
        EXC_OV   = 5'd12
    } exc_code_e;

    function automatic logic [31:0] pack_cause(input logic bd, input logic ti,
                                               input logic [7:0] ip, input logic [4:0] code);
        logic [31:0] c;
        c = 32'h0000_0000;
        c[CA_BD] = bd;
        c[CA_TI] = ti;
        c[CA_IP_LO +: 8] = ip;
        c[CA_EXC_LO +: 5] = code;
        return c;
    endfunction

endpackage

// File: rtl/cp0_timer_intr_count_timer.sv
// Count/Compare timer: prescaled Count, Compare register and the sticky
// timer-interrupt flag raised one cycle after an updated Count hits Compare.
module cp0_count_timer #(
    parameter int COUNT_DIV = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        count_we,
    input  logic        compare_we,
    input  logic [31:0] wdata,
    output logic [31:0] count,
    output logic [31:0] compare,
    output logic        ti
);
    localparam logic [3:0] DIV_LAST = 4'(COUNT_DIV - 1);

    logic [3:0]  div_q, div_d;
    logic [31:0] count_q, count_d;
    logic [31:0] compare_q, compare_d;
    logic        hit_q, hit_d;
    logic        ti_q, ti_d;
    logic        wrap_s;

    // Next-state for divider, Count, Compare and TI.
    always_comb begin
        div_d     = div_q;
        count_d   = count_q;
        compare_d = compare_q;
        ti_d      = ti_q;
        wrap_s    = (div_q == DIV_LAST);
        if (count_we) begin
            count_d = wdata;
            div_d   = 4'd0;
        end else if (wrap_s) begin
            count_d = count_q + 32'd1;
            div_d   = 4'd0;
        end else begin
            div_d = div_q + 4'd1;
        end
        if (compare_we) begin
            compare_d = wdata;
        end else begin
            compare_d = compare_q;
        end
        // Only a Count update can hit, so a parked Count never re-arms TI.
        hit_d = (count_we || wrap_s) && (count_d == compare_d);
        if (compare_we) begin
            ti_d = 1'b0;
        end else if (hit_q) begin
            ti_d = 1'b1;
        end else begin
            ti_d = ti_q;
        end
    end

    // Timer state registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            div_q     <= 4'd0;
            count_q   <= 32'd0;
            compare_q <= 32'd0;
            hit_q     <= 1'b0;
            ti_q      <= 1'b0;
        end else begin
            div_q     <= div_d;
            count_q   <= count_d;
            compare_q <= compare_d;
            hit_q     <= hit_d;
            ti_q      <= ti_d;
        end
    end

    assign count   = count_q;
    assign compare = compare_q;
    assign ti      = ti_q;

endmodule

// File: rtl/cp0_timer_intr.sv
// Coprocessor-0 register file with Count/Compare timer, hardware/software
// interrupts, exception commit and ERET; MFC0 reads forward this cycle's update.
module cp0_timer_intr
    import cp0_timer_intr_pkg::*;
#(
    parameter int          N_HINT     = 6,
    parameter int          COUNT_DIV  = 2,
    parameter logic [31:0] PRID_VAL   = 32'h0001_8000,
    parameter logic [31:0] STATUS_RST = 32'h0000_ff01
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [4:0]        rd_addr,
    output logic [31:0]       rd_data,
    input  logic              wr_en,
    input  logic [4:0]        wr_addr,
    input  logic [31:0]       wr_data,
    input  logic              exc_we,
    input  logic              exc_bd,
    input  logic [4:0]        exc_code,
    input  logic [31:0]       exc_epc,
    input  logic [31:0]       exc_bva,
    input  logic              exc_bva_we,
    input  logic              eret,
    input  logic [N_HINT-1:0] hard_intr,
    output logic              intr_pending,
    output logic [31:0]       er_epc,
    output logic              timer_intr
);
    logic [31:0] bva_q, bva_d;
    logic [31:0] epc_q, epc_d;
    logic [31:0] status_q, status_d;
    logic [1:0]  ip_sw_q, ip_sw_d;
    logic [5:0]  ip_hw_q, ip_hw_d;
    logic        bd_q, bd_d;
    logic [4:0]  code_q, code_d;

    logic        wr_ok_s, count_we_s, compare_we_s, ti_s, exl_eff_s;
    logic [31:0] count_s, compare_s, status_fwd_s, cause_fwd_s;
    logic [7:0]  ip_fwd_s;

    assign wr_ok_s      = wr_en && !exc_we && !eret;
    assign count_we_s   = wr_ok_s && (wr_addr == CP0_COUNT);
    assign compare_we_s = wr_ok_s && (wr_addr == CP0_COMPARE);

    cp0_count_timer #(.COUNT_DIV(COUNT_DIV)) u_timer (
        .clk        (clk),
        .rst        (rst),
        .count_we   (count_we_s),
        .compare_we (compare_we_s),
        .wdata      (wr_data),
        .count      (count_s),
        .compare    (compare_s),
        .ti         (ti_s)
    );

    // Prioritised next-state: exception commit, then ERET, then MTC0.
    always_comb begin
        bva_d    = bva_q;
        epc_d    = epc_q;
        status_d = status_q;
        ip_sw_d  = ip_sw_q;
        bd_d     = bd_q;
        code_d   = code_q;
        ip_hw_d  = 6'd0;
        ip_hw_d[N_HINT-1:0] = hard_intr;
        if (exc_we) begin
            bd_d             = exc_bd;
            code_d           = exc_code;
            status_d[ST_EXL] = 1'b1;
            epc_d            = exc_epc;
            if (exc_bva_we) begin
                bva_d = exc_bva;
            end else begin
                bva_d = bva_q;
            end
        end else if (eret) begin
            status_d[ST_EXL] = 1'b0;
        end else if (wr_en) begin
            case (wr_addr)
                CP0_STATUS: status_d = wr_data & STATUS_WMASK;
                CP0_CAUSE:  ip_sw_d  = wr_data[CA_IP_LO +: 2];
                CP0_EPC:    epc_d    = wr_data;
                default:    status_d = status_q;
            endcase
        end else begin
            status_d = status_q;
        end
    end

    // Forwarded views; ERET's EXL clear only shows up in intr_pending.
    always_comb begin
        if (eret && !exc_we) begin
            status_fwd_s = status_q;
        end else begin
            status_fwd_s = status_d;
        end
        ip_fwd_s    = {ip_hw_q[5] | ti_s, ip_hw_q[4:0], ip_sw_d};
        cause_fwd_s = pack_cause(bd_d, ti_s, ip_fwd_s, code_d);
        if (exc_we) begin
            exl_eff_s = 1'b1;
        end else if (eret) begin
            exl_eff_s = 1'b0;
        end else begin
            exl_eff_s = status_fwd_s[ST_EXL];
        end
        case (rd_addr)
            CP0_BADVADDR: rd_data = bva_d;
            CP0_COUNT:    rd_data = count_we_s ? wr_data : count_s;
            CP0_COMPARE:  rd_data = compare_we_s ? wr_data : compare_s;
            CP0_STATUS:   rd_data = status_fwd_s;
            CP0_CAUSE:    rd_data = cause_fwd_s;
            CP0_EPC:      rd_data = epc_d;
            CP0_PRID:     rd_data = PRID_VAL;
            default:      rd_data = 32'h0000_0000;
        endcase
    end

    assign intr_pending = (|(ip_fwd_s & status_fwd_s[ST_IM_LO +: 8]))
                          & status_fwd_s[ST_IE] & ~exl_eff_s;
    assign er_epc       = exc_we ? exc_epc : epc_d;
    assign timer_intr   = ti_s;

    // CP0 architectural registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            bva_q    <= 32'd0;
            epc_q    <= 32'd0;
            status_q <= STATUS_RST & STATUS_WMASK;
            ip_sw_q  <= 2'd0;
            ip_hw_q  <= 6'd0;
            bd_q     <= 1'b0;
            code_q   <= 5'd0;
        end else begin
            bva_q    <= bva_d;
            epc_q    <= epc_d;
            status_q <= status_d;
            ip_sw_q  <= ip_sw_d;
            ip_hw_q  <= ip_hw_d;
            bd_q     <= bd_d;
            code_q   <= code_d;
        end
    end

endmodule

// File: doc/cp0_timer_intr.md
Name: cp0_timer_intr

Overview:
- Parametrised successor to the existing coprocessor-0 block.
- Holds BadVAddr, Count, Compare, Status, Cause, EPC and PRId.
- Adds a Count/Compare timer with a timer interrupt, a configurable number of hardware interrupt lines, writable software interrupts, and ERET handling that clears Status.EXL.
- Sits beside the writeback/exception stage. Reads are serviced combinationally for MFC0, writes come from MTC0, and the exception-commit port has priority over both.

Parameters:
- N_HINT, 6: number of hardware interrupt lines (1..6); they map to Cause.IP[2+N_HINT-1:2], and unused IP bits read 0.
- COUNT_DIV, 2: Count increments once every COUNT_DIV clocks (1..16).
- PRID_VAL, 32'h00018000: read-only value of PRId (reg 15).
- STATUS_RST, 32'h0000ff01: reset value of Status.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-low
- rd_addr  in  5  MFC0 register index
- rd_data  out  32  MFC0 read data, combinational
- wr_en  in  1  MTC0 write strobe
- wr_addr  in  5  MTC0 register index
- wr_data  in  32  MTC0 write data
- exc_we  in  1  exception commit strobe
- exc_bd  in  1  faulting instruction is in a delay slot
- exc_code  in  5  Cause.ExcCode value
- exc_epc  in  32  EPC value
- exc_bva  in  32  BadVAddr value
- exc_bva_we  in  1  update BadVAddr (address exceptions only)
- eret  in  1  ERET commit strobe
- hard_intr  in  N_HINT  level-sensitive external interrupts
- intr_pending  out  1  an interrupt should be taken next commit
- er_epc  out  32  exception/ERET return address
- timer_intr  out  1  Cause.TI

Behaviour:
- Reset, when rst=0 at a clk edge:
  - Count=0, Compare=0, Cause=0, EPC=0, BadVAddr=0, Status=STATUS_RST, divider counter=0.
  - Outputs settle in the same cycle: timer_intr=0, intr_pending=0.
- Register map:
  - 8 BadVAddr (read-only to MTC0).
  - 9 Count (RW).
  - 11 Compare (RW).
  - 12 Status: bits 15:8 IM, 1 EXL, 0 IE are writable; all other bits read 0.
  - 13 Cause: only IP[1:0] (bits 9:8) are writable by MTC0. Other fields: 31 BD, 30 TI, 15:10 IP hardware, 6:2 ExcCode.
  - 14 EPC (RW).
  - 15 PRId (read-only).
  - Every other index reads 0, and writes to it are ignored.
- Write priority in one cycle: exc_we > eret > wr_en.
  - A lower-priority request in the same cycle is dropped entirely.
  - Exception: the Cause.IP hardware bits, Cause.TI and Count advance independently of this priority.
- Exception commit (exc_we=1): next cycle Cause.BD=exc_bd, Cause.ExcCode=exc_code, Status.EXL=1, EPC=exc_epc, and BadVAddr=exc_bva if exc_bva_we.
- ERET (eret=1, exc_we=0): next cycle Status.EXL=0. Other registers are unchanged.
- Hardware IP:
  - Cause.IP[2+i] is registered from hard_intr[i] every cycle: one cycle of latency, no latching.
  - Cause.IP[7] = registered hard_intr[5] (if N_HINT=6) OR TI.
- Count and the timer:
  - The divider counts 0..COUNT_DIV-1. When it wraps, Count increments, wrapping 2^32-1 to 0.
  - An MTC0 write to Count loads wr_data, resets the divider, and overrides the increment in that cycle.
  - TI is set in the cycle after the updated Count equals Compare; it stays set until cleared.
  - An MTC0 write to Compare clears TI. Set and clear in the same cycle: the clear wins.
- Forwarding (matches existing cp0 semantics):
  - rd_data returns the value the register will hold after this cycle's write.
  - If exc_we=1, rd_data for 8/12/13/14 returns the exception-updated fields.
  - Otherwise, if wr_en and wr_addr==rd_addr, rd_data returns the wr_data masked to its writable bits.
  - Otherwise rd_data returns the stored value.
- er_epc = exc_epc if exc_we, else the forwarded EPC.
- intr_pending:
  - Equals |(IP & IM) & IE & ~EXL.
  - Uses forwarded Status and Cause, with EXL taken as 1 if exc_we and as 0 if eret.
- Reset mid-operation: reset overrides every strobe in the same cycle, and any pending TI is lost.

Decomposition:
- Shared package `includes`:
  - CP0 register index constants (CP0_BADVADDR=8, CP0_COUNT=9, CP0_COMPARE=11, CP0_STATUS=12, CP0_CAUSE=13, CP0_EPC=14, CP0_PRID=15).
  - Status/Cause bit position constants.
  - Writable-bit masks.
  - An ExcCode enum.
- Sub-module cp0_count_timer: holds the divider, Count, Compare-match and TI set/clear logic. Ports: clk, rst, count_we, compare_we, wdata, count, compare, ti.

Test Plan:
- Reset (rst=0 one cycle), then read reg 12 and reg 15 -> 32'h0000ff01 and PRId; Count=0; intr_pending=0.
- COUNT_DIV=2; write Compare=5, Count=0 -> TI rises after Count reaches 5, about 10 clocks later; intr_pending=1 (IM7=1, IE=1); write Compare=5 again -> TI=0 next cycle.
- hard_intr[0]=1 with IM2=1, IE=1 -> intr_pending=1 one cycle later; exc_we with exc_code=0, exc_epc=32'hBFC00100 -> same-cycle er_epc=BFC00100, intr_pending=0; next cycle EXL=1.
- exc_we and wr_en(reg 14, 32'h1234) in the same cycle -> EPC=exc_epc and the MTC0 write is dropped; then eret -> EXL=0 next cycle.
- wr_en reg 13 with 32'hFFFFFFFF, reading reg 13 in the same cycle -> rd_data shows only IP[1:0] set plus the existing hardware bits; a write to BadVAddr is ignored.
- Count=32'hFFFFFFFF, COUNT_DIV=1 -> Count wraps to 0 next cycle; a write to Count in the same cycle as the increment takes the written value.
